matvec_seq_mac: RTL

//   Sequential 4x4 matrix-vector multiplier: Y = A * X, unsigned.

---
 rtl/matvec_seq_mac.sv | 132 +++++++++++++
 1 files changed

// File: rtl/matvec_seq_mac.sv
// Sequential 4x4 unsigned matrix-vector multiplier (Y = A*X) using one shared
// N x N multiplier over 16 cycles, with valid/ready handshakes on both sides.
module matvec_seq_mac #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*N-1:0]   A1,
  input  logic [4*N-1:0]   A2,
  input  logic [4*N-1:0]   A3,
  input  logic [4*N-1:0]   A4,
  input  logic [N-1:0]     X1,
  input  logic [N-1:0]     X2,
  input  logic [N-1:0]     X3,
  input  logic [N-1:0]     X4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N+1:0]   Y1,
  output logic [2*N+1:0]   Y2,
  output logic [2*N+1:0]   Y3,
  output logic [2*N+1:0]   Y4
);

  localparam int AW = 2*N + 2;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state_q, state_d;
  logic [4*N-1:0]   a_q [4];
  logic [4*N-1:0]   a_d [4];
  logic [N-1:0]     x_q [4];
  logic [N-1:0]     x_d [4];
  logic [AW-1:0]    acc_q [4];
  logic [AW-1:0]    acc_d [4];
  logic [AW-1:0]    y_q [4];
  logic [AW-1:0]    y_d [4];
  logic [3:0]       idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [1:0]       row, col;
  logic [N-1:0]     a_el, x_el;
  logic [2*N-1:0]   prod;

  always_comb begin
    row  = idx_q[3:2];
    col  = idx_q[1:0];
    // Element 1 of each row sits in the MSBs, so column c is at slice 3-c.
    a_el = a_q[row][N*(3 - int'(col)) +: N];
    x_el = x_q[col];
    prod = {{N{1'b0}}, a_el} * {{N{1'b0}}, x_el};

    state_d     = state_q;
    a_d         = a_q;
    x_d         = x_q;
    acc_d       = acc_q;
    y_d         = y_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = '{A1, A2, A3, A4};
          x_d        = '{X1, X2, X3, X4};
          acc_d      = '{default: '0};
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d[row] = acc_q[row] + AW'(prod);
        idx_d      = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          y_d         = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        a_q[i]   <= '0;
        x_q[i]   <= '0;
        acc_q[i] <= '0;
        y_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      for (int unsigned i = 0; i < 4; i++) begin
        a_q[i]   <= a_d[i];
        x_q[i]   <= x_d[i];
        acc_q[i] <= acc_d[i];
        y_q[i]   <= y_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Y1 = y_q[0];
  assign Y2 = y_q[1];
  assign Y3 = y_q[2];
  assign Y4 = y_q[3];

endmodule
